// File: rtl/sr5_deser.sv
// sr5_deser: serial-to-parallel deserializer with a double-buffered output word.
// Optional all-ones MATCH flag is built when SR5_DESER_MATCH_EN is defined.
module sr5_deser #(
  parameter int              WIDTH     = 5,
  parameter bit              MSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] INIT     = '0
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             D,
  input  logic             SOF,
  output logic [WIDTH-1:0] Q,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF,
  output logic             MATCH
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_ovf;

  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_first;
  logic             w_last;
  logic             w_done;
  logic             w_free;
  logic             w_take;

  // Shift direction decides where the first received bit ends up.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sh[WIDTH-2:0], D};
      assign w_first   = {{(WIDTH-1){1'b0}}, D};
    end else begin : g_lsb
      assign w_shifted = {D, r_sh[WIDTH-1:1]};
      assign w_first   = {D, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  // The bit sampled while the counter reads WIDTH-1 closes the frame.
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_done = (r_state == S_SHIFT) && CE
                  && !SOF && w_last;
  assign w_free = !r_valid || READY;
  assign w_take = r_valid && READY;

  // Shift FSM: frame start, bit collection, restart on SOF.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else if (CE) begin
      if (SOF) begin
        r_state <= S_SHIFT;
        r_cnt   <= CW'(1);
        r_sh    <= w_first;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_SHIFT: begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
              r_sh    <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
              r_sh  <= w_shifted;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Output stage: load, drop-with-overrun, or release on handshake.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_q     <= INIT;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_done && w_free) begin
      r_q     <= w_shifted;
      r_valid <= 1'b1;
    end else if (w_done) begin
      r_ovf   <= 1'b1;
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  assign Q     = r_q;
  assign VALID = r_valid;
  assign OVF   = r_ovf;

`ifdef SR5_DESER_MATCH_EN
  logic r_match;

  // All-ones flag tracks the word loaded into Q and drops with VALID.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      r_match <= 1'b0;
    end else if (w_done && w_free) begin
      r_match <= &w_shifted;
    end else if (!w_done && w_take) begin
      r_match <= 1'b0;
    end
  end

  assign MATCH = r_match;
`else
  assign MATCH = 1'b0;
`endif

endmodule

// File: tb/tb_sr5_deser.sv
// tb_sr5_deser: directed table plus randomized run against a frame-level model.
// Checks an MSB-first and an LSB-first instance side by side.
module tb_sr5_deser;

  logic       C = 1'b0;
  logic       CLR;
  logic       CE, D, SOF, READY;
  logic [4:0] q_m, q_l;
  logic       v_m, v_l, o_m, o_l, m_m, m_l;

  int npass = 0;
  int ntot  = 0;

  sr5_deser #(.WIDTH(5), .MSB_FIRST(1'b1), .INIT(5'd0)) dut (
    .C(C), .CLR(CLR), .CE(CE), .D(D), .SOF(SOF),
    .Q(q_m), .VALID(v_m), .READY(READY),
    .OVF(o_m), .MATCH(m_m)
  );

  sr5_deser #(.WIDTH(5), .MSB_FIRST(1'b0), .INIT(5'd0)) dut_l (
    .C(C), .CLR(CLR), .CE(CE), .D(D), .SOF(SOF),
    .Q(q_l), .VALID(v_l), .READY(READY),
    .OVF(o_l), .MATCH(m_l)
  );

  always #5 C = ~C;

  // frame-level reference model
  bit         bits[$];
  bit         inf;
  logic [4:0] mq, mql;
  bit         mv, movf, mmatch;

  task automatic model_reset();
    bits.delete();
    inf = 0; mq = 0; mql = 0;
    mv = 0; movf = 0; mmatch = 0;
  endtask

  task automatic model_edge();
    bit comp;
    logic [4:0] wm, wl;
    comp = 0; wm = 0; wl = 0;
    if (CE) begin
      if (SOF) begin
        bits.delete();
        bits.push_back(D);
        inf = 1;
      end else if (inf) begin
        bits.push_back(D);
      end
      if (inf && bits.size() == 5) begin
        comp = 1;
        for (int i = 0; i < 5; i++) begin
          wm[4-i] = bits[i];
          wl[i]   = bits[i];
        end
        bits.delete();
        inf = 0;
      end
    end
    if (comp) begin
      if (!mv || READY) begin
        mq = wm; mql = wl; mv = 1;
        mmatch = (wm == 5'b11111);
      end else begin
        movf = 1;
      end
    end else if (mv && READY) begin
      mv = 0; mmatch = 0;
    end
  endtask

  function automatic bit exp_match(bit m);
`ifdef SR5_DESER_MATCH_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic chk_model(string tag);
    chk({tag, " q_msb"}, {27'd0, q_m}, {27'd0, mq});
    chk({tag, " q_lsb"}, {27'd0, q_l}, {27'd0, mql});
    chk({tag, " valid"}, {30'd0, v_m, v_l}, {30'd0, mv, mv});
    chk({tag, " ovf"}, {30'd0, o_m, o_l}, {30'd0, movf, movf});
    chk({tag, " match"}, {30'd0, m_m, m_l},
        {30'd0, exp_match(mmatch), exp_match(mql == 5'b11111 && mv)});
  endtask

  task automatic step(input bit ce, sof, d, rdy);
    @(negedge C);
    CE = ce; SOF = sof; D = d; READY = rdy;
    @(posedge C);
    model_edge();
    #1;
  endtask

  // async reset pulse between edges, checked before the next edge
  task automatic clr_pulse(string tag);
    @(negedge C);
    CE = 0; SOF = 0; D = 0; READY = 0;
    #2 CLR = 1;
    model_reset();
    #1;
    chk({tag, " clr q"}, {27'd0, q_m}, 32'd0);
    chk({tag, " clr v/o/m"}, {29'd0, v_m, o_m, m_m}, 32'd0);
    #1 CLR = 0;
    @(posedge C);
    model_edge();
    #1;
  endtask

  typedef struct {
    bit         clr;
    bit         ce, sof, d, rdy;
    logic [4:0] q;
    bit         v, o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit clr, bit ce, bit sof, bit d, bit rdy,
                              logic [4:0] q, bit v, bit o);
    vec_t r;
    r.clr = clr; r.ce = ce; r.sof = sof; r.d = d; r.rdy = rdy;
    r.q = q; r.v = v; r.o = o;
    return r;
  endfunction

  initial begin
    CLR = 1; CE = 0; D = 0; SOF = 0; READY = 0;
    model_reset();
    #2;
    chk("reset q", {27'd0, q_m}, 32'd0);
    chk("reset v/o/m", {29'd0, v_m, o_m, m_m}, 32'd0);
    @(negedge C);
    CLR = 0;

    // 1: bits 1,0,1,1,0
    tbl.push_back(mk(0,1,1,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    // 2: unread, second frame 0,0,0,0,1 overruns
    tbl.push_back(mk(0,1,1,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,1));
    tbl.push_back(mk(0,0,0,0,0, 5'd22,1,1));
    // 3: reload after clr, then 11111 with READY on completion
    tbl.push_back(mk(1,1,1,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,1,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,1, 5'd31,1,0));
    tbl.push_back(mk(0,0,0,0,1, 5'd31,0,0));
    tbl.push_back(mk(0,0,0,0,1, 5'd31,0,0));
    // 4: restart after 3 bits, then 0,1,0,1,0
    tbl.push_back(mk(0,1,1,1,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,1,0,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd31,0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd10,1,0));
    // 5: CE toggling, bits 1,0,1,1,0, READY on completion
    tbl.push_back(mk(0,1,1,1,0, 5'd10,1,0));
    tbl.push_back(mk(0,0,0,1,0, 5'd10,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd10,1,0));
    tbl.push_back(mk(0,0,0,1,0, 5'd10,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd10,1,0));
    tbl.push_back(mk(0,0,0,0,0, 5'd10,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd10,1,0));
    tbl.push_back(mk(0,1,0,0,1, 5'd22,1,0));
    // SOF on the would-be last bit discards the frame
    tbl.push_back(mk(0,1,1,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,1,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd22,1,0));
    tbl.push_back(mk(0,1,0,1,1, 5'd1, 1,0));
    // 6: clr after 2 bits, then 0,1,1,0,1
    tbl.push_back(mk(0,1,1,1,0, 5'd1, 1,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd1, 1,0));
    tbl.push_back(mk(1,1,1,0,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,0,0, 5'd0, 0,0));
    tbl.push_back(mk(0,1,0,1,0, 5'd13,1,0));

    foreach (tbl[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (tbl[i].clr) clr_pulse(tag);
      step(tbl[i].ce, tbl[i].sof, tbl[i].d, tbl[i].rdy);
      chk({tag, " q"}, {27'd0, q_m}, {27'd0, tbl[i].q});
      chk({tag, " valid"}, {31'd0, v_m}, {31'd0, tbl[i].v});
      chk({tag, " ovf"}, {31'd0, o_m}, {31'd0, tbl[i].o});
      chk({tag, " match"}, {31'd0, m_m},
          {31'd0, exp_match(tbl[i].v && tbl[i].q == 5'd31)});
      chk_model(tag);
    end

    // LSB-first rerun of frame 1,0,1,1,0 -> 01101
    clr_pulse("lsb");
    step(1,1,1,0); step(1,0,0,0); step(1,0,1,0);
    step(1,0,1,0); step(1,0,0,0);
    chk("lsb q", {27'd0, q_l}, 32'h0d);
    chk("lsb valid", {31'd0, v_l}, 32'd1);

    // randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      bit ce, sof, d, rdy;
      if ($urandom_range(0, 119) == 0) clr_pulse($sformatf("rnd%0d", n));
      ce  = ($urandom_range(0, 3) != 0);
      sof = ($urandom_range(0, 11) == 0);
      d   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      step(ce, sof, d, rdy);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
